axis_demux: RTL

- 1:2 AXI-Stream packet router; the counterpart of the 2:1 stream arbiter.
- Accepts one 32-bit slave stream and steers each whole packet to master A or master B, selected by the TDEST of the packet's first beat.
- Packets with unroutable destinations are consumed and discarded, and counted.
- Each master output has a one-deep registered elastic stage, so no combinational path exists from m*_tready to s_axis_tready beyond one AND/OR level.

---
 rtl/axis_demux.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/axis_demux.sv
// axis_demux: 1:2 AXI-Stream packet router; the first-beat TDEST steers a whole packet to A, B or drop.
// Define AXIS_DEMUX_BCAST_EN to make tdest=3 broadcast to both masters instead of dropping.
module axis_demux #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [1:0]        s_axis_tdest,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] ma_axis_tdata,
  output logic              ma_axis_tvalid,
  input  logic              ma_axis_tready,
  output logic              ma_axis_tlast,
  output logic [DATA_W-1:0] mb_axis_tdata,
  output logic              mb_axis_tvalid,
  input  logic              mb_axis_tready,
  output logic              mb_axis_tlast,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [2:0] {IDLE, PKT_A, PKT_B, PKT_DROP, PKT_BC} state_t;
  typedef enum logic [1:0] {ROUTE_A, ROUTE_B, ROUTE_DROP, ROUTE_BC} route_t;

  state_t            state_q, state_d;
  route_t            route;
  logic              ackA, ackB, xfer, loadA, loadB, dropDone;
  logic              maValid_q, maValid_d, mbValid_q, mbValid_d;
  logic [DATA_W-1:0] maData_q, mbData_q;
  logic              maLast_q, mbLast_q;
  logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;

  assign ackA = ~maValid_q | ma_axis_tready;
  assign ackB = ~mbValid_q | mb_axis_tready;

  // Only the first beat of a packet looks at tdest; later beats follow the latched packet state.
  always_comb begin
    route = ROUTE_DROP;
    case (state_q)
      PKT_A:    route = ROUTE_A;
      PKT_B:    route = ROUTE_B;
      PKT_DROP: route = ROUTE_DROP;
      PKT_BC:   route = ROUTE_BC;
      default: begin
        case (s_axis_tdest)
          2'd0:    route = ROUTE_A;
          2'd1:    route = ROUTE_B;
`ifdef AXIS_DEMUX_BCAST_EN
          2'd3:    route = ROUTE_BC;
`endif
          default: route = ROUTE_DROP;
        endcase
      end
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    if (axis_aresetn) begin
      case (route)
        ROUTE_A:  s_axis_tready = ackA;
        ROUTE_B:  s_axis_tready = ackB;
        ROUTE_BC: s_axis_tready = ackA & ackB;
        default:  s_axis_tready = 1'b1;
      endcase
    end
  end

  assign xfer     = s_axis_tvalid & s_axis_tready;
  assign loadA    = xfer & ((route == ROUTE_A) | (route == ROUTE_BC));
  assign loadB    = xfer & ((route == ROUTE_B) | (route == ROUTE_BC));
  assign dropDone = xfer & s_axis_tlast & (route == ROUTE_DROP);

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      if (state_q == IDLE) begin
        if (!s_axis_tlast) begin
          case (route)
            ROUTE_A:  state_d = PKT_A;
            ROUTE_B:  state_d = PKT_B;
            ROUTE_BC: state_d = PKT_BC;
            default:  state_d = PKT_DROP;
          endcase
        end
      end else if (s_axis_tlast) begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    maValid_d = maValid_q;
    mbValid_d = mbValid_q;
    dropCnt_d = dropCnt_q;
    if (loadA) begin
      maValid_d = 1'b1;
    end else if (ma_axis_tready) begin
      maValid_d = 1'b0;
    end
    if (loadB) begin
      mbValid_d = 1'b1;
    end else if (mb_axis_tready) begin
      mbValid_d = 1'b0;
    end
    if (dropDone && !(&dropCnt_q)) begin
      dropCnt_d = dropCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q   <= IDLE;
      maValid_q <= 1'b0;
      mbValid_q <= 1'b0;
      dropCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      maValid_q <= maValid_d;
      mbValid_q <= mbValid_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  // Payload registers carry no reset; their valid flags qualify them.
  always_ff @(posedge axis_aclk) begin
    if (loadA) begin
      maData_q <= s_axis_tdata;
      maLast_q <= s_axis_tlast;
    end
    if (loadB) begin
      mbData_q <= s_axis_tdata;
      mbLast_q <= s_axis_tlast;
    end
  end

  assign ma_axis_tdata  = maData_q;
  assign ma_axis_tvalid = maValid_q;
  assign ma_axis_tlast  = maLast_q;
  assign mb_axis_tdata  = mbData_q;
  assign mb_axis_tvalid = mbValid_q;
  assign mb_axis_tlast  = mbLast_q;
  assign drop_cnt       = dropCnt_q;

endmodule
